// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator slice: default widths, signed data
// types, FSM state encoding and accumulator clamp limits.
package mac_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int CNT_W_DEF  = 16;

    typedef logic signed [PROD_W_DEF-1:0] prod_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_sat_add.sv
// Signed W-bit adder reporting two's-complement overflow. With MAC_ACC_SAT_EN
// defined, overflowing results clamp to the most positive/negative value.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] raw;

    // Overflow only when both operands share a sign the result does not.
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef MAC_ACC_SAT_EN
        if (ovf)
            sum = a[W-1] ? SAT_MIN : SAT_MAX;
        else
            sum = raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// Streams signed products into a wide accumulator and emits one registered
// sum per vector. Optional clamping arithmetic is selected by MAC_ACC_SAT_EN.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = '1;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ovf_q;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_sum;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     add_ovf;
    logic                     accept;
    logic                     beat_last;
    logic                     load;
    logic [CNT_W-1:0]         cnt_inc;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign prod_ext  = ACC_W'(in_prod);
    assign cnt_inc   = cnt_q + 1'b1;
    // A full counter forces a split so out_beats never wraps.
    assign beat_last = in_last || (cnt_q == CNT_LIMIT - 1'b1);
    assign load      = accept && beat_last;

    mac_sat_add #(.W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

`ifdef MAC_ACC_SAT_EN
    // Once clamped, the accumulator stays pinned for the rest of the vector.
    assign acc_next = ovf_q ? acc_q : add_sum;
`else
    assign acc_next = add_sum;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !beat_last) state_d = ACCUM;
            ACCUM:   if (load)                 state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (beat_last) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_inc;
                    ovf_q <= ovf_q || add_ovf;
                end
            end
            // A new load wins over a simultaneous drain, keeping the slot full.
            if (load) begin
                out_data  <= acc_next;
                out_beats <= cnt_inc;
                out_ovf   <= ovf_q || add_ovf;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
